l2_memory_responder: RTL and testbench
======================================

// Module: l2_memory_responder
// PURPOSE
// - Responder end of the core's L2 requester port: accepts read/write bursts pushed by the core, serves them from a
//   word-addressed on-chip memory, returns read beats with a sub_id tag. Sits below the L1 arbiter in sim/FPGA builds.
// PARAMETERS
// - MEM_WORDS        4096  memory depth in 32-bit words; power of two; address index = addr[$clog2(MEM_WORDS)-1:0]
// - REQ_FIFO_DEPTH   4     request FIFO entries (power of two, >=2)
// - WR_FIFO_DEPTH    8     write-data FIFO entries (power of two, >=2)
// - READ_LATENCY     2     cycles from read-request dequeue to first beat valid (>=1)
// PORTS
// - clk                 in   1   clock
// - rst                 in   1   synchronous active-high reset
// - addr                in   30  word address of request
// - rnw                 in   1   1=read, 0=write
// - is_amo              in   1   request is LR/SC (used only with L2_RESP_AMO_EN)
// - amo_type_or_burst   in   5   burst length minus 1 (beats = value+1, 1..32)
// - sub_id              in   2   requester tag, echoed on read data
// - request_push        in   1   enqueue request; ignored while request_full
// - request_full        out  1   request FIFO full
// - wr_data             in   32  write beat
// - wr_data_push        in   1   enqueue write beat; ignored while data_full
// - data_full           out  1   write-data FIFO full
// - rd_data             out  32  read beat
// - rd_sub_id           out  2   tag of current read beat
// - rd_data_valid       out  1   read beat valid
// - rd_data_ack         in   1   beat consumed when valid&ack
// - con_result          out  1   SC success (1) / fail (0)
// - con_valid           out  1   one-cycle strobe qualifying con_result
// BEHAVIOUR
// - Reset: both FIFOs empty, FSM=IDLE, request_full=0, data_full=0, rd_data_valid=0, rd_data=0, rd_sub_id=0,
//   con_valid=0, con_result=0, latency/beat counters 0. Memory contents not reset. Reset mid-burst aborts it.
// - FIFOs: push when push&!full; full asserted combinationally from count; push and pop same cycle when full is
//   illegal (push blocked), same cycle when empty-pop not possible. Pointers wrap modulo depth.
// - FSM IDLE: if request FIFO non-empty, pop head into regs {addr,rnw,len,sub_id,amo}; beat counter=0;
//   rnw=1 -> RD_WAIT (latency counter=READ_LATENCY-1), rnw=0 -> WR.
// - RD_WAIT: decrement; at 0 -> RD_BURST with rd_data_valid=1, rd_data=mem[addr]. READ_LATENCY=1: beat valid the
//   cycle after dequeue.
// - RD_BURST: rd_data/rd_sub_id held stable while valid&!ack. On ack: if beat==len -> IDLE (valid=0 next cycle),
//   else beat++, next word presented next cycle (back-to-back, 1 beat/cycle max). Word index = (addr+beat) mod
//   MEM_WORDS (wraps to 0 at top).
// - WR: each cycle write FIFO non-empty, pop one beat, mem[(addr+beat) mod MEM_WORDS]=beat data; after beat==len
//   -> IDLE. Empty FIFO stalls WR without error. Write beats may arrive before or after their request.
// - Read-after-write ordering: requests served strictly in FIFO order; a read queued after a write returns the
//   written data.
// - rd_data_ack without rd_data_valid ignored.
// CONFIGURATION
// - L2_RESP_AMO_EN defined: single reservation {valid, word addr}. Read with is_amo=1 (LR) sets reservation to
//   its addr. Write with is_amo=1 (SC, len must be 0): if reservation valid & addr match -> write performed,
//   con_result=1; else write beat popped and discarded, con_result=0; con_valid pulses 1 cycle when SC beat
//   consumed; reservation cleared either way. Any non-AMO write overlapping the reserved word clears it.
//   Reservation cleared on reset.
// - Not defined: is_amo ignored (treated as plain read/write), no reservation logic, con_valid/con_result tied 0.
// TESTING
// - Write 4 beats 0xA0..0xA3 to addr 0x10 (burst=3), then read burst=3 same addr -> beats 0xA0..0xA3, sub_id echoed.
// - READ_LATENCY=2, single read, ack held high -> rd_data_valid rises exactly 2 cycles after dequeue, 1 cycle wide.
// - Read burst=7 with ack toggled 1/0 -> rd_data stable while unacked, 8 beats, no beat skipped/duplicated.
// - Push REQ_FIFO_DEPTH+1 reads while ack=0 -> request_full=1, extra push dropped, all queued reads later served.
// - Burst=1 write at addr MEM_WORDS-1 -> second word lands at index 0; read back confirms wrap.
// - AMO_EN: LR 0x20, SC 0x20 data 0x55 -> con_valid&con_result=1, mem=0x55; second SC 0x20 -> con_result=0, unchanged.

Source files
------------

// File: rtl/l2_memory_responder_if.sv
// Core-to-L2 responder port: request push, write-data push, read-beat return and SC result.
interface l2_memory_responder_if;
  logic [29:0] addr;
  logic        rnw;
  logic        is_amo;
  logic [4:0]  amo_type_or_burst;
  logic [1:0]  sub_id;
  logic        request_push;
  logic        request_full;
  logic [31:0] wr_data;
  logic        wr_data_push;
  logic        data_full;
  logic [31:0] rd_data;
  logic [1:0]  rd_sub_id;
  logic        rd_data_valid;
  logic        rd_data_ack;
  logic        con_result;
  logic        con_valid;

  modport master (
    output addr, rnw, is_amo, amo_type_or_burst, sub_id, request_push,
           wr_data, wr_data_push, rd_data_ack,
    input  request_full, data_full, rd_data, rd_sub_id, rd_data_valid,
           con_result, con_valid
  );

  modport slave (
    input  addr, rnw, is_amo, amo_type_or_burst, sub_id, request_push,
           wr_data, wr_data_push, rd_data_ack,
    output request_full, data_full, rd_data, rd_sub_id, rd_data_valid,
           con_result, con_valid
  );
endinterface

// File: rtl/l2_memory_responder.sv
// L2 responder: queued read/write bursts served from on-chip word memory.
// Optional LR/SC reservation support is enabled by defining L2_RESP_AMO_EN.
module l2_memory_responder #(
  parameter int MEM_WORDS      = 4096,
  parameter int REQ_FIFO_DEPTH = 4,
  parameter int WR_FIFO_DEPTH  = 8,
  parameter int READ_LATENCY   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  l2_memory_responder_if.slave  bus
);
  localparam int AW  = $clog2(MEM_WORDS);
  localparam int RPW = $clog2(REQ_FIFO_DEPTH);
  localparam int WPW = $clog2(WR_FIFO_DEPTH);
  localparam int LW  = $clog2(READ_LATENCY + 1);

  typedef struct packed {
    logic [29:0] addr;
    logic        rnw;
    logic        amo;
    logic [4:0]  len;
    logic [1:0]  sub_id;
  } req_t;

  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_BURST, WR} state_t;

  state_t        state_q, state_d;
  logic [29:0]   addr_q;
  logic          amo_q;
  logic [4:0]    len_q, beat_q;
  logic [1:0]    sub_id_q;
  logic [LW-1:0] lat_q;
  logic          last_beat;
  logic          req_pop, wr_pop, rd_load, rd_valid, mem_we;
  logic [AW-1:0] rd_idx, wr_idx;

  // ---------------- request FIFO ----------------
  req_t           req_mem [REQ_FIFO_DEPTH];
  logic [RPW-1:0] req_wp, req_rp;
  logic [RPW:0]   req_cnt;
  logic           req_push;
  req_t           req_head;

  assign bus.request_full = (req_cnt == (RPW+1)'(REQ_FIFO_DEPTH));
  assign req_push         = bus.request_push && !bus.request_full;
  assign req_head         = req_mem[req_rp];

  // NOTE: FIFO storage and the memory array carry no reset; only pointers and counters do.
  always_ff @(posedge clk) begin
    if (req_push)
      req_mem[req_wp] <= {bus.addr, bus.rnw, bus.is_amo, bus.amo_type_or_burst, bus.sub_id};
  end

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_wp  <= '0;
      req_rp  <= '0;
      req_cnt <= '0;
    end else begin
      if (req_push) req_wp <= req_wp + RPW'(1);
      if (req_pop)  req_rp <= req_rp + RPW'(1);
      req_cnt <= req_cnt + (RPW+1)'(req_push) - (RPW+1)'(req_pop);
    end
  end

  // ---------------- write-data FIFO ----------------
  logic [31:0]    wr_mem [WR_FIFO_DEPTH];
  logic [WPW-1:0] wr_wp, wr_rp;
  logic [WPW:0]   wr_cnt;
  logic           wr_push;
  logic [31:0]    wr_head;

  assign bus.data_full = (wr_cnt == (WPW+1)'(WR_FIFO_DEPTH));
  assign wr_push       = bus.wr_data_push && !bus.data_full;
  assign wr_head       = wr_mem[wr_rp];

  always_ff @(posedge clk) begin
    if (wr_push) wr_mem[wr_wp] <= bus.wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_wp  <= '0;
      wr_rp  <= '0;
      wr_cnt <= '0;
    end else begin
      if (wr_push) wr_wp <= wr_wp + WPW'(1);
      if (wr_pop)  wr_rp <= wr_rp + WPW'(1);
      wr_cnt <= wr_cnt + (WPW+1)'(wr_push) - (WPW+1)'(wr_pop);
    end
  end

  // ---------------- FSM ----------------
  assign last_beat = (beat_q == len_q);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (req_cnt != '0) begin
        if (!req_head.rnw)          state_d = WR;
        else if (READ_LATENCY == 1) state_d = RD_BURST;
        else                        state_d = RD_WAIT;
      end
      RD_WAIT:  if (lat_q == LW'(1)) state_d = RD_BURST;
      RD_BURST: if (bus.rd_data_ack && last_beat) state_d = IDLE;
      WR:       if (wr_cnt != '0 && last_beat) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    req_pop  = 1'b0;
    wr_pop   = 1'b0;
    rd_load  = 1'b0;
    rd_valid = 1'b0;
    case (state_q)
      IDLE: begin
        req_pop = (req_cnt != '0);
        rd_load = req_pop && req_head.rnw && (READ_LATENCY == 1);
      end
      RD_WAIT:  rd_load = (lat_q == LW'(1));
      RD_BURST: begin
        rd_valid = 1'b1;
        rd_load  = bus.rd_data_ack && !last_beat;
      end
      WR:       wr_pop = (wr_cnt != '0);
      default:  ;
    endcase
  end

  // Burst registers; beat index wraps the memory modulo MEM_WORDS via AW-bit adds.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q   <= '0;
      amo_q    <= 1'b0;
      len_q    <= '0;
      sub_id_q <= '0;
      beat_q   <= '0;
      lat_q    <= '0;
    end else begin
      if (req_pop) begin
        addr_q   <= req_head.addr;
        amo_q    <= req_head.amo;
        len_q    <= req_head.len;
        sub_id_q <= req_head.sub_id;
        beat_q   <= '0;
        lat_q    <= LW'(READ_LATENCY - 1);
      end
      if (state_q == RD_WAIT) lat_q <= lat_q - LW'(1);
      if ((state_q == RD_BURST && bus.rd_data_ack && !last_beat) || wr_pop)
        beat_q <= beat_q + 5'd1;
    end
  end

  // Read address: head of queue when skipping RD_WAIT, else the beat about to be presented.
  always_comb begin
    rd_idx = addr_q[AW-1:0] + AW'(beat_q);
    if (state_q == IDLE)          rd_idx = req_head.addr[AW-1:0];
    else if (state_q == RD_BURST) rd_idx = addr_q[AW-1:0] + AW'(beat_q) + AW'(1);
  end

  assign wr_idx = addr_q[AW-1:0] + AW'(beat_q);

  // ---------------- memory ----------------
  logic [31:0] mem [MEM_WORDS];
  logic [31:0] rd_q;

  always_ff @(posedge clk) begin
    if (mem_we)  mem[wr_idx] <= wr_head;
    if (rd_load) rd_q <= mem[rd_idx];
  end

  // Read register has no reset, so the visible beat is masked to 0 when not valid.
  assign bus.rd_data       = rd_valid ? rd_q : '0;
  assign bus.rd_data_valid = rd_valid;
  assign bus.rd_sub_id     = sub_id_q;

`ifdef L2_RESP_AMO_EN
  logic        resv_valid_q;
  logic [29:0] resv_addr_q;
  logic        sc_ok, con_valid_q, con_result_q;

  assign sc_ok  = resv_valid_q && (resv_addr_q == addr_q);
  assign mem_we = wr_pop && !rst && (!amo_q || sc_ok);

  always_ff @(posedge clk) begin
    if (rst) begin
      resv_valid_q <= 1'b0;
      resv_addr_q  <= '0;
      con_valid_q  <= 1'b0;
      con_result_q <= 1'b0;
    end else begin
      con_valid_q  <= wr_pop && amo_q;
      con_result_q <= wr_pop && amo_q && sc_ok;
      if (req_pop && req_head.rnw && req_head.amo) begin
        resv_valid_q <= 1'b1;
        resv_addr_q  <= req_head.addr;
      end else if (wr_pop && (amo_q || wr_idx == resv_addr_q[AW-1:0])) begin
        resv_valid_q <= 1'b0;
      end
    end
  end

  assign bus.con_valid  = con_valid_q;
  assign bus.con_result = con_result_q;
`else
  logic unused_amo;
  assign unused_amo     = ^{amo_q, addr_q[29:AW]};
  assign mem_we         = wr_pop && !rst;
  assign bus.con_valid  = 1'b0;
  assign bus.con_result = 1'b0;
`endif

endmodule

// File: tb/tb_l2_memory_responder.sv
// Scoreboard bench for l2_memory_responder: random bursts against a flat-array memory model.
module tb_l2_memory_responder;
  localparam int MEM_WORDS      = 4096;
  localparam int REQ_FIFO_DEPTH = 4;
  localparam int WR_FIFO_DEPTH  = 8;
  localparam int READ_LATENCY   = 2;
`ifdef L2_RESP_AMO_EN
  localparam bit AMO_EN = 1'b1;
`else
  localparam bit AMO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  l2_memory_responder_if bus();

  l2_memory_responder #(
    .MEM_WORDS(MEM_WORDS), .REQ_FIFO_DEPTH(REQ_FIFO_DEPTH),
    .WR_FIFO_DEPTH(WR_FIFO_DEPTH), .READ_LATENCY(READ_LATENCY)
  ) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct { logic [31:0] data; logic [1:0] sid; bit known; } beat_t;

  beat_t       exp_q[$];
  bit          con_q[$];
  logic [31:0] ref_mem   [MEM_WORDS];
  bit          ref_known [MEM_WORDS];
  bit          resv_v;
  logic [29:0] resv_a;
  logic [31:0] wbuf [32];
  int          checks = 0;
  int          errors = 0;
  int          ack_mode = 1;  // 0 low, 1 high, 2 toggle, 3 random

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired", name);
  endtask

  // ---------------- drivers ----------------
  task automatic push_req(input logic [29:0] a, input bit rnw, input bit amo,
                          input logic [4:0] len, input logic [1:0] sid);
    int n = 0;
    while (bus.request_full && n < 3000) begin @(posedge clk); #1; n++; end
    if (bus.request_full) fail_now("request_push_wait");
    bus.addr = a; bus.rnw = rnw; bus.is_amo = amo;
    bus.amo_type_or_burst = len; bus.sub_id = sid;
    bus.request_push = 1'b1;
    @(posedge clk); #1;
    bus.request_push = 1'b0;
  endtask

  task automatic push_wr(input logic [31:0] d);
    int n = 0;
    while (bus.data_full && n < 3000) begin @(posedge clk); #1; n++; end
    if (bus.data_full) fail_now("data_push_wait");
    bus.wr_data = d;
    bus.wr_data_push = 1'b1;
    @(posedge clk); #1;
    bus.wr_data_push = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || con_q.size() != 0) && n < 5000) begin @(posedge clk); #1; n++; end
    if (exp_q.size() != 0 || con_q.size() != 0) fail_now("drain_wait");
    repeat (40) @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  task automatic model_write(input logic [29:0] a, input int len, input bit amo);
    bit do_write;
    int idx;
    do_write = 1'b1;
    if (AMO_EN && amo) begin
      do_write = resv_v && (resv_a == a);
      con_q.push_back(do_write);
      resv_v = 1'b0;
    end
    for (int b = 0; b <= len; b++) begin
      idx = (int'(a) + b) % MEM_WORDS;
      if (do_write) begin ref_mem[idx] = wbuf[b]; ref_known[idx] = 1'b1; end
      if (AMO_EN && !amo && resv_v && idx == int'(resv_a) % MEM_WORDS) resv_v = 1'b0;
    end
  endtask

  task automatic write_txn(input logic [29:0] a, input int len, input bit amo, input bit data_first);
    model_write(a, len, amo);
    if (data_first) begin
      for (int b = 0; b <= len; b++) push_wr(wbuf[b]);
      push_req(a, 1'b0, amo, 5'(len), 2'($urandom));
    end else begin
      push_req(a, 1'b0, amo, 5'(len), 2'($urandom));
      for (int b = 0; b <= len; b++) push_wr(wbuf[b]);
    end
  endtask

  task automatic expect_read(input logic [29:0] a, input int len, input logic [1:0] sid, input bit amo);
    int idx;
    for (int b = 0; b <= len; b++) begin
      idx = (int'(a) + b) % MEM_WORDS;
      exp_q.push_back('{data: ref_mem[idx], sid: sid, known: ref_known[idx]});
    end
    if (AMO_EN && amo) begin resv_v = 1'b1; resv_a = a; end
  endtask

  task automatic issue_read(input logic [29:0] a, input int len, input logic [1:0] sid, input bit amo);
    expect_read(a, len, sid, amo);
    push_req(a, 1'b1, amo, 5'(len), sid);
  endtask

  // ---------------- ack driver ----------------
  initial begin
    bus.rd_data_ack = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ack_mode)
        0:       bus.rd_data_ack = 1'b0;
        1:       bus.rd_data_ack = 1'b1;
        2:       bus.rd_data_ack = ~bus.rd_data_ack;
        default: bus.rd_data_ack = 1'($urandom);
      endcase
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    bit          hold;
    logic [31:0] hd;
    logic [1:0]  hs;
    beat_t       e;
    bit          c;
    hold = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold = 1'b0;
      end else begin
        if (hold) begin
          check("hold_valid", 32'(bus.rd_data_valid), 32'd1);
          check("hold_data", bus.rd_data, hd);
          check("hold_sub_id", 32'(bus.rd_sub_id), 32'(hs));
        end
        hold = 1'b0;
        if (bus.rd_data_valid) begin
          if (bus.rd_data_ack) begin
            if (exp_q.size() == 0) begin
              fail_now("unexpected_beat");
            end else begin
              e = exp_q.pop_front();
              if (e.known) check("rd_data", bus.rd_data, e.data);
              check("rd_sub_id", 32'(bus.rd_sub_id), 32'(e.sid));
            end
          end else begin
            hold = 1'b1;
            hd = bus.rd_data;
            hs = bus.rd_sub_id;
          end
        end
        if (bus.con_valid) begin
          if (con_q.size() == 0) begin
            fail_now("unexpected_con_valid");
          end else begin
            c = con_q.pop_front();
            check("con_result", 32'(bus.con_result), 32'(c));
          end
        end
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    bus.addr = '0; bus.rnw = 1'b0; bus.is_amo = 1'b0; bus.amo_type_or_burst = '0;
    bus.sub_id = '0; bus.request_push = 1'b0; bus.wr_data = '0; bus.wr_data_push = 1'b0;
    resv_v = 1'b0; resv_a = '0;
    for (int i = 0; i < MEM_WORDS; i++) ref_known[i] = 1'b0;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_request_full", 32'(bus.request_full), 32'd0);
    check("rst_data_full", 32'(bus.data_full), 32'd0);
    check("rst_rd_data_valid", 32'(bus.rd_data_valid), 32'd0);
    check("rst_rd_data", bus.rd_data, 32'd0);
    check("rst_rd_sub_id", 32'(bus.rd_sub_id), 32'd0);
    check("rst_con_valid", 32'(bus.con_valid), 32'd0);
    check("rst_con_result", 32'(bus.con_result), 32'd0);

    // 4-beat write then read-back with a tag
    for (int b = 0; b < 4; b++) wbuf[b] = 32'hA0 + 32'(b);
    write_txn(30'h10, 3, 1'b0, 1'b0);
    issue_read(30'h10, 3, 2'd2, 1'b0);
    wait_idle();

    // read latency with ack held high
    issue_read(30'h11, 0, 2'd1, 1'b0);
    check("lat_dequeue_cycle", 32'(bus.rd_data_valid), 32'd0);
    @(posedge clk); #1;
    check("lat_cycle_1", 32'(bus.rd_data_valid), 32'd0);
    @(posedge clk); #1;
    check("lat_cycle_2", 32'(bus.rd_data_valid), 32'd1);
    @(posedge clk); #1;
    check("lat_cycle_3", 32'(bus.rd_data_valid), 32'd0);
    wait_idle();

    // 8-beat read with toggling ack
    for (int b = 0; b < 8; b++) wbuf[b] = $urandom;
    write_txn(30'h200, 7, 1'b0, 1'b1 ^ 1'b1);
    ack_mode = 2;
    issue_read(30'h200, 7, 2'd3, 1'b0);
    wait_idle();

    // request FIFO fill with ack held low; extra push must be dropped
    ack_mode = 0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i <= REQ_FIFO_DEPTH; i++) begin
      expect_read(30'h10 + 30'(i % 4), 0, 2'(i), 1'b0);
      bus.addr = 30'h10 + 30'(i % 4); bus.rnw = 1'b1; bus.is_amo = 1'b0;
      bus.amo_type_or_burst = 5'd0; bus.sub_id = 2'(i); bus.request_push = 1'b1;
      @(posedge clk); #1;
    end
    bus.request_push = 1'b0;
    check("request_full_set", 32'(bus.request_full), 32'd1);
    bus.addr = 30'h200; bus.request_push = 1'b1;
    @(posedge clk); #1;
    bus.request_push = 1'b0;
    check("request_full_hold", 32'(bus.request_full), 32'd1);
    ack_mode = 3;
    wait_idle();
    check("queued_reads_served", 32'(exp_q.size()), 32'd0);
    ack_mode = 1;

    // write-data FIFO fill; extra beat must be dropped
    for (int b = 0; b < WR_FIFO_DEPTH; b++) begin wbuf[b] = $urandom; push_wr(wbuf[b]); end
    check("data_full_set", 32'(bus.data_full), 32'd1);
    bus.wr_data = 32'hDEAD_BEEF; bus.wr_data_push = 1'b1;
    @(posedge clk); #1;
    bus.wr_data_push = 1'b0;
    model_write(30'h400, WR_FIFO_DEPTH - 1, 1'b0);
    push_req(30'h400, 1'b0, 1'b0, 5'(WR_FIFO_DEPTH - 1), 2'd0);
    wbuf[0] = 32'h1234_5678;
    write_txn(30'h400 + 30'(WR_FIFO_DEPTH), 0, 1'b0, 1'b0);
    issue_read(30'h400, WR_FIFO_DEPTH, 2'd1, 1'b0);
    wait_idle();
    check("data_full_clear", 32'(bus.data_full), 32'd0);

    // address wrap at the top of memory
    wbuf[0] = 32'hCAFE_0001; wbuf[1] = 32'hCAFE_0002;
    write_txn(30'(MEM_WORDS - 1), 1, 1'b0, 1'b0);
    issue_read(30'(MEM_WORDS - 1), 1, 2'd2, 1'b0);
    issue_read(30'h0, 0, 2'd3, 1'b0);
    wait_idle();

    // LR / SC sequence (plain read/write when AMO support is absent)
    wbuf[0] = 32'h11;
    write_txn(30'h20, 0, 1'b0, 1'b0);
    issue_read(30'h20, 0, 2'd1, 1'b1);
    wbuf[0] = 32'h55;
    write_txn(30'h20, 0, 1'b1, 1'b0);
    wbuf[0] = 32'h66;
    write_txn(30'h20, 0, 1'b1, 1'b0);
    issue_read(30'h20, 0, 2'd3, 1'b0);
    wait_idle();

    // randomized mix
    ack_mode = 3;
    for (int t = 0; t < 150; t++) begin
      logic [29:0] a;
      int          len;
      int          idx;
      bit          amo;
      idx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(MEM_WORDS - 6, MEM_WORDS - 1))
                                         : int'($urandom_range(0, 47));
      a   = 30'(idx) | (($urandom_range(0, 1) != 0) ? 30'h2AAA_A000 : 30'h0);
      amo = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) != 0) begin
        issue_read(a, int'($urandom_range(0, 15)), 2'($urandom), amo);
      end else begin
        len = amo ? 0 : int'($urandom_range(0, 7));
        for (int b = 0; b <= len; b++) wbuf[b] = $urandom;
        write_txn(a, len, amo, (len < 4) && ($urandom_range(0, 1) != 0));
      end
    end
    wait_idle();
    check("final_read_queue_empty", 32'(exp_q.size()), 32'd0);
    check("final_con_queue_empty", 32'(con_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
